midori_shared_core: RTL and testbench
=====================================

MIDORI_SHARED_CORE -- requirements
Module: midori_shared_core

Interface
REQ-001 The block SHALL have parameter NUM_SHARES, default 3, giving the number of Boolean shares of the state (legal values 3 or 4).
REQ-002 The block SHALL have parameter SBOX_STAGES, default 2, giving the register depth inside the shared nonlinear layer (legal values 1..4).
REQ-003 The block SHALL have parameter NUM_ROUNDS, default 16, giving the number of S-layer passes including the final one.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request to encrypt; sampled only in IDLE.
REQ-007 pt_sh  input  64*NUM_SHARES  plaintext shares; share i occupies bits [64*i+63:64*i].
REQ-008 MK0  input  64  key half K0 (upper 64 bits of the 128-bit key), unshared.
REQ-009 MK1  input  64  key half K1 (lower 64 bits), unshared.
REQ-010 busy  output  1  high from start acceptance until done.
REQ-011 done  output  1  one-cycle pulse when ct_sh is valid.
REQ-012 ct_sh  output  64*NUM_SHARES  ciphertext shares, same packing as pt_sh.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE: start=1 -> RUN; capture pt_sh; share 0 XORed with WK = MK0^MK1; round counter r=0; phase counter p=0.
- RUN: each S-layer pass SHALL last P = SBOX_STAGES+1 cycles; p counts 0..P-1 and wraps; r increments on wrap.
- RUN with r=NUM_ROUNDS-1 and p=P-1 -> DONE.
- DONE: lasts exactly one cycle -> IDLE.
REQ-014 Passes r=0..NUM_ROUNDS-2 SHALL apply, per share: shared S-layer, ShuffleCell, MixColumn; share 0 only SHALL then be XORed with RK_r = (r even ? MK0 : MK1) ^ expand(alpha_r), where alpha_r is the 16-bit Midori64 round constant.
REQ-015 Pass r=NUM_ROUNDS-1 SHALL apply the S-layer only; share 0 SHALL then be XORed with WK, and the result SHALL be registered into ct_sh.
REQ-016 Linear layers and key addition SHALL act share-wise; no share SHALL combine with another outside the S-layer; no fresh randomness SHALL be consumed.
REQ-017 done SHALL assert exactly NUM_ROUNDS*P cycles after the cycle in which start was accepted (48 cycles at default parameters).
REQ-018 busy SHALL be 1 from the cycle after start acceptance through the done cycle inclusive, and 0 otherwise.
REQ-019 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored; start in the cycle after done SHALL be accepted (back-to-back throughput NUM_ROUNDS*P+1 cycles).
REQ-020 ct_sh SHALL hold its value from done until the next done; pt_sh, MK0 and MK1 SHALL be required stable while busy=1.
REQ-021 XOR of all ct_sh shares SHALL equal Midori64(K0||K1, XOR of all pt_sh shares) for any sharing.

Reset
REQ-022 rst=1 SHALL force: FSM=IDLE, r=0, p=0, busy=0, done=0, ct_sh=0, and all state and S-layer pipeline registers=0.
REQ-023 rst asserted mid-operation SHALL abort the encryption with no done pulse; start in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-024 Package midori_pkg SHALL hold: the alpha round constant table, the expand function mapping 16-bit alpha to 64 bits (one bit per nibble LSB), the shuffle permutation, and the FSM state typedef.
REQ-025 One sub-module, midori_shared_slayer (parametrised by NUM_SHARES and SBOX_STAGES), SHALL implement the decomposed shared S-layer; the shuffle, MixColumn and key addition SHALL be inline.

Verification
REQ-026 Key 0x0...0 (128 bit), pt 0x0000000000000000, 3 random shares -> XOR(ct_sh)=0x3c9cceda2bbd449a, done at cycle 48 after start.
REQ-027 Key 0x687ded3b3c85b3f35b1009863e2a8cbf, pt 0x42c20fd3b586879e, NUM_SHARES=4, SBOX_STAGES=1 -> XOR(ct_sh)=0x66bcdc6270d901cd, done at cycle 32.
REQ-028 start pulsed again at cycles 5 and 47 of a run -> both ignored; exactly one done pulse; busy continuously high.
REQ-029 rst at cycle 20 of a run -> busy=0 and ct_sh=0 next cycle, no done; a fresh start then yields the correct ciphertext.
REQ-030 start held high continuously for 3 encryptions -> done pulses 49 cycles apart, each ciphertext correct.

Source files
------------

// File: rtl/midori_pkg.sv
// rtl/midori_pkg.sv - Midori64 constants, cell permutation, round-constant expansion and FSM state type
//
// Contents: fsm_state_t, SB0 (Midori Sb0), ALPHA (16-bit round constants),
// SHUFFLE (ShuffleCell source index per destination cell), expand_alpha,
// shuffle_cells, mix_columns, sb0_anf (algebraic normal form of Sb0).
// Cell i of a 64-bit state occupies bits [63-4i:60-4i].
package midori_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [3:0] SB0 [16] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    // Last entry is never used by a legal round index; it keeps the table a power of two.
    localparam logic [15:0] ALPHA [16] = '{
        16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f, 16'hd170, 16'h0266, 16'h0bcc,
        16'h9481, 16'h40b8, 16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90, 16'h0000
    };

    localparam logic [3:0] SHUFFLE [16] = '{
        4'd0, 4'd10, 4'd5, 4'd15, 4'd14, 4'd4, 4'd11, 4'd1,
        4'd9, 4'd3, 4'd12, 4'd6, 4'd7, 4'd13, 4'd2, 4'd8
    };

    // Alpha bit for cell i (bit 15-i) lands in the LSB of that cell.
    function automatic logic [63:0] expand_alpha(input logic [15:0] a);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[4*k] = a[k];
        return v;
    endfunction

    function automatic logic [63:0] shuffle_cells(input logic [63:0] s);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[60-4*i +: 4] = s[60-4*int'(SHUFFLE[i]) +: 4];
        return v;
    endfunction

    // Each cell becomes the XOR of the other three cells of its column.
    function automatic logic [63:0] mix_columns(input logic [63:0] s);
        logic [63:0] v;
        logic [3:0]  col;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[60-16*c +: 4] ^ s[56-16*c +: 4] ^ s[52-16*c +: 4] ^ s[48-16*c +: 4];
            for (int j = 0; j < 4; j++) v[60-16*c-4*j +: 4] = col ^ s[60-16*c-4*j +: 4];
        end
        return v;
    endfunction

    // ANF coefficient of monomial m (bit k of m selects input bit k) for all four output bits.
    function automatic logic [3:0] sb0_anf(input logic [3:0] m);
        logic [3:0] acc;
        acc = '0;
        for (int x = 0; x < 16; x++) begin
            if ((4'(x) & ~m) == 4'd0) acc = acc ^ SB0[x];
        end
        return acc;
    endfunction

endpackage

// File: rtl/midori_shared_slayer.sv
// rtl/midori_shared_slayer.sv - shared Midori64 S-layer with SBOX_STAGES output registers
//
// Ports: clk, rst (sync, active-high), din (shared state, share j at [64j+63:64j]),
//        dout (shared S-layer result, SBOX_STAGES cycles after din).
module midori_shared_slayer #(
    parameter int NUM_SHARES  = 3,
    parameter int SBOX_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [64*NUM_SHARES-1:0] din,
    output logic [64*NUM_SHARES-1:0] dout
);
    import midori_pkg::*;

    localparam int W = 64*NUM_SHARES;

    logic [W-1:0]              pipe_q [SBOX_STAGES];
    logic [W-1:0]              pipe_d [SBOX_STAGES];
    logic [W-1:0]              sb_out;
    logic [4*NUM_SHARES-1:0]   xn;
    logic [4*NUM_SHARES-1:0]   yn;

    // Every monomial of the Sb0 ANF is expanded over all share tuples. Each
    // cross-share product is credited to the lowest-numbered share that does not
    // feed it, so an output share avoids its own input share wherever the tuple
    // leaves one free; otherwise it goes to share 0. The XOR of the output
    // shares is exactly Sb0 of the XOR of the input shares.
    function automatic logic [4*NUM_SHARES-1:0] shared_sbox(input logic [4*NUM_SHARES-1:0] x);
        logic [4*NUM_SHARES-1:0] y;
        logic [3:0]              coef;
        logic [1:0]              idx;
        logic [3:0]              used;
        logic                    ok;
        logic                    term;
        int                      owner;
        y      = '0;
        y[3:0] = sb0_anf(4'd0);
        for (int m = 1; m < 16; m++) begin
            coef = sb0_anf(4'(m));
            for (int t = 0; t < 256; t++) begin
                ok   = 1'b1;
                term = 1'b1;
                used = '0;
                for (int k = 0; k < 4; k++) begin
                    idx = 2'(t >> (2*k));
                    if (int'(idx) >= NUM_SHARES) begin
                        ok = 1'b0;
                    end else if (m[k]) begin
                        term      = term & x[4*int'(idx) + k];
                        used[idx] = 1'b1;
                    end else if (idx != 2'd0) begin
                        ok = 1'b0;
                    end
                end
                owner = 0;
                for (int s = NUM_SHARES-1; s >= 0; s--) begin
                    if (!used[s]) owner = s;
                end
                if (ok && term) y[4*owner +: 4] = y[4*owner +: 4] ^ coef;
            end
        end
        return y;
    endfunction

    always_comb begin
        xn     = '0;
        yn     = '0;
        sb_out = '0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < NUM_SHARES; j++) xn[4*j +: 4] = din[64*j + 4*k +: 4];
            yn = shared_sbox(xn);
            for (int j = 0; j < NUM_SHARES; j++) sb_out[64*j + 4*k +: 4] = yn[4*j +: 4];
        end
        pipe_d[0] = sb_out;
        for (int i = 1; i < SBOX_STAGES; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SBOX_STAGES; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[SBOX_STAGES-1];

endmodule

// File: rtl/midori_shared_core.sv
// rtl/midori_shared_core.sv - Boolean-shared Midori64 encryption core
//
// Ports: clk, rst (sync, active-high), start (accepted in IDLE), pt_sh (shared
//        plaintext), MK0/MK1 (key halves), busy, done (one-cycle pulse),
//        ct_sh (shared ciphertext, held until the next done).
module midori_shared_core #(
    parameter int NUM_SHARES  = 3,
    parameter int SBOX_STAGES = 2,
    parameter int NUM_ROUNDS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [64*NUM_SHARES-1:0] pt_sh,
    input  logic [63:0]              MK0,
    input  logic [63:0]              MK1,
    output logic                     busy,
    output logic                     done,
    output logic [64*NUM_SHARES-1:0] ct_sh
);
    import midori_pkg::*;

    localparam int         W      = 64*NUM_SHARES;
    localparam logic [2:0] P_LAST = 3'(SBOX_STAGES);
    localparam logic [7:0] R_LAST = 8'(NUM_ROUNDS-1);

    fsm_state_t   fsm_q, fsm_d;
    logic [7:0]   r_q, r_d;
    logic [2:0]   p_q, p_d;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] ct_q, ct_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [63:0]  wk;
    logic [63:0]  rk;
    logic [W-1:0] wk_sh;
    logic [W-1:0] load_val;
    logic [W-1:0] sl_in;
    logic [W-1:0] sl_out;
    logic [W-1:0] lin_out;
    logic [W-1:0] fin_out;

    assign wk       = MK0 ^ MK1;
    assign wk_sh    = {{(W-64){1'b0}}, wk};
    assign load_val = pt_sh ^ wk_sh;
    // The accept cycle already presents the whitened plaintext to the S-layer,
    // so pass 0 spends only P-1 cycles in RUN and done lands NUM_ROUNDS*P
    // cycles after acceptance.
    assign sl_in    = (fsm_q == IDLE) ? load_val : state_q;
    assign rk       = (r_q[0] ? MK1 : MK0) ^ expand_alpha(ALPHA[r_q[3:0]]);
    assign fin_out  = sl_out ^ wk_sh;

    midori_shared_slayer #(
        .NUM_SHARES  (NUM_SHARES),
        .SBOX_STAGES (SBOX_STAGES)
    ) u_slayer (
        .clk  (clk),
        .rst  (rst),
        .din  (sl_in),
        .dout (sl_out)
    );

    always_comb begin
        lin_out = '0;
        for (int j = 0; j < NUM_SHARES; j++) begin
            lin_out[64*j +: 64] = mix_columns(shuffle_cells(sl_out[64*j +: 64]));
        end
        lin_out[63:0] = lin_out[63:0] ^ rk;
    end

    always_comb begin
        fsm_d   = fsm_q;
        r_d     = r_q;
        p_d     = p_q;
        state_d = state_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    fsm_d   = RUN;
                    state_d = load_val;
                    r_d     = '0;
                    p_d     = 3'd1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (r_q == R_LAST) begin
                        ct_d   = fin_out;
                        fsm_d  = DONE;
                        done_d = 1'b1;
                    end else begin
                        state_d = lin_out;
                        r_d     = r_q + 8'd1;
                    end
                end else begin
                    p_d = p_q + 3'd1;
                end
            end
            DONE: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
                r_d    = '0;
                p_d    = '0;
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            r_q     <= '0;
            p_q     <= '0;
            state_q <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            r_q     <= r_d;
            p_q     <= p_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ct_sh = ct_q;

endmodule

// File: tb/tb_midori_shared_core.sv
// tb/tb_midori_shared_core.sv - vector table and corner-case sequences for midori_shared_core
module tb_midori_shared_core;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start3, start4;
    logic [191:0] pt3;
    logic [255:0] pt4;
    logic [63:0]  mk0, mk1;
    logic         busy3, done3, busy4, done4;
    logic [191:0] ct3;
    logic [255:0] ct4;

    int n_vec = 0;
    int n_bad = 0;

    midori_shared_core dut3 (
        .clk(clk), .rst(rst), .start(start3), .pt_sh(pt3), .MK0(mk0), .MK1(mk1),
        .busy(busy3), .done(done3), .ct_sh(ct3)
    );

    midori_shared_core #(.NUM_SHARES(4), .SBOX_STAGES(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .pt_sh(pt4), .MK0(mk0), .MK1(mk1),
        .busy(busy4), .done(done4), .ct_sh(ct4)
    );

    localparam logic [3:0]  TB_SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    localparam int          TB_SH [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
    localparam logic [15:0] TB_RC [15] = '{16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
                                           16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
                                           16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90};

    // Unshared reference Midori64, cell by cell.
    function automatic logic [63:0] ref_enc(input logic [127:0] key, input logic [63:0] pt);
        logic [3:0]  s [16];
        logic [3:0]  t [16];
        logic [3:0]  col;
        logic [15:0] a;
        logic [63:0] k0, k1, wk, rk, out;
        k0 = key[127:64];
        k1 = key[63:0];
        wk = k0 ^ k1;
        out = '0;
        for (int i = 0; i < 16; i++) s[i] = pt[63-4*i -: 4] ^ wk[63-4*i -: 4];
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 16; i++) t[i] = TB_SB[s[TB_SH[i]]];
            rk = (r % 2 == 0) ? k0 : k1;
            a  = TB_RC[r];
            for (int c = 0; c < 4; c++) begin
                col = t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = col ^ t[4*c+j] ^ rk[63-4*(4*c+j) -: 4] ^ {3'b000, a[15-(4*c+j)]};
            end
        end
        for (int i = 0; i < 16; i++) out[63-4*i -: 4] = TB_SB[s[i]] ^ wk[63-4*i -: 4];
        return out;
    endfunction

    function automatic logic [63:0] xor3(input logic [191:0] v);
        return v[63:0] ^ v[127:64] ^ v[191:128];
    endfunction

    function automatic logic [63:0] xor4(input logic [255:0] v);
        return v[63:0] ^ v[127:64] ^ v[191:128] ^ v[255:192];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [191:0] share3(input logic [63:0] pt);
        logic [63:0] r1, r2;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        return {r2, r1, pt ^ r1 ^ r2};
    endfunction

    function automatic logic [255:0] share4(input logic [63:0] pt);
        logic [63:0] r1, r2, r3;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        r3 = {$urandom, $urandom};
        return {r3, r2, r1, pt ^ r1 ^ r2 ^ r3};
    endfunction

    // Called at a falling edge; start is presented for exactly one cycle.
    task automatic run_enc(input bit use4, input logic [127:0] key, input logic [63:0] pt,
                           input logic [63:0] exp_ct, input string tag);
        int lat;
        int busy_low;
        mk0 = key[127:64];
        mk1 = key[63:0];
        if (use4) begin
            pt4    = share4(pt);
            start4 = 1'b1;
        end else begin
            pt3    = share3(pt);
            start3 = 1'b1;
        end
        @(negedge clk);
        start3   = 1'b0;
        start4   = 1'b0;
        lat      = 0;
        busy_low = 0;
        for (int k = 1; k <= 100; k++) begin
            if (!(use4 ? busy4 : busy3)) busy_low++;
            if (use4 ? done4 : done3) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_ct"}, use4 ? xor4(ct4) : xor3(ct3), exp_ct);
        check({tag, "_latency"}, 64'(lat), use4 ? 64'd32 : 64'd48);
        check({tag, "_busy_gaps"}, 64'(busy_low), 64'd0);
        @(negedge clk);
        check({tag, "_idle_after"}, {62'd0, (use4 ? busy4 : busy3), (use4 ? done4 : done3)}, 64'd0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  ct;
        bit           use4;
    } vec_t;

    vec_t tbl [7];

    localparam logic [127:0] KEY2 = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
    localparam logic [63:0]  PT2  = 64'h42c20fd3b586879e;
    localparam logic [63:0]  CT2  = 64'h66bcdc6270d901cd;
    localparam logic [63:0]  CT0  = 64'h3c9cceda2bbd449a;

    int dones;
    int dcyc;
    int blow;
    int b49;
    int dlist [3];

    initial begin
        rst    = 1'b1;
        start3 = 1'b0;
        start4 = 1'b0;
        pt3    = '0;
        pt4    = '0;
        mk0    = 64'hffff_0000_ffff_0000;
        mk1    = 64'h1234_5678_9abc_def0;

        tbl[0] = '{128'h0, 64'h0, CT0, 1'b0};
        tbl[1] = '{KEY2, PT2, CT2, 1'b0};
        tbl[2] = '{KEY2, PT2, CT2, 1'b1};
        tbl[3] = '{{128{1'b1}}, 64'hffff_ffff_ffff_ffff, 64'h0, 1'b0};
        tbl[4] = '{128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 64'h0123_4567_89ab_cdef, 64'h0, 1'b0};
        tbl[5] = '{128'hdead_beef_0bad_f00d_cafe_babe_1357_9bdf, 64'h8000_0000_0000_0001, 64'h0, 1'b1};
        tbl[6] = '{128'h0, 64'h0, CT0, 1'b1};
        for (int i = 3; i < 6; i++) tbl[i].ct = ref_enc(tbl[i].key, tbl[i].pt);

        repeat (3) @(negedge clk);
        check("rst_busy3", {63'd0, busy3}, 64'd0);
        check("rst_done3", {63'd0, done3}, 64'd0);
        check("rst_ct3", xor3(ct3) | ct3[191:128] | ct3[127:64], 64'd0);
        check("rst_busy4", {63'd0, busy4}, 64'd0);
        check("rst_done4", {63'd0, done4}, 64'd0);
        check("rst_ct4", ct4[255:192] | ct4[191:128] | ct4[127:64] | ct4[63:0], 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_enc(tbl[i].use4, tbl[i].key, tbl[i].pt, tbl[i].ct, $sformatf("vec%0d", i));
        end

        // Extra start pulses at cycles 5 and 47 of a run are ignored.
        mk0    = KEY2[127:64];
        mk1    = KEY2[63:0];
        pt3    = share3(PT2);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        dones  = 0;
        dcyc   = 0;
        blow   = 0;
        b49    = 0;
        for (int k = 1; k <= 60; k++) begin
            start3 = (k == 5 || k == 47);
            if (done3) begin
                dones++;
                if (dcyc == 0) dcyc = k;
            end
            if (k <= 48 && !busy3) blow++;
            if (k == 49) b49 = int'(busy3);
            @(negedge clk);
        end
        start3 = 1'b0;
        check("seqA_done_count", 64'(dones), 64'd1);
        check("seqA_done_cycle", 64'(dcyc), 64'd48);
        check("seqA_busy_gaps", 64'(blow), 64'd0);
        check("seqA_busy_after", 64'(b49), 64'd0);
        check("seqA_ct", xor3(ct3), CT2);

        // Reset at cycle 20 aborts the run; start right after reset is accepted.
        mk0    = tbl[4].key[127:64];
        mk1    = tbl[4].key[63:0];
        pt3    = share3(tbl[4].pt);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        dones  = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done3) dones++;
            if (k == 20) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        if (done3) dones++;
        check("seqB_busy_after_rst", {63'd0, busy3}, 64'd0);
        check("seqB_ct_after_rst", ct3[191:128] | ct3[127:64] | ct3[63:0], 64'd0);
        check("seqB_no_done", 64'(dones), 64'd0);
        run_enc(1'b0, tbl[4].key, tbl[4].pt, tbl[4].ct, "seqB_restart");

        // start held high: back-to-back encryptions 49 cycles apart.
        mk0    = tbl[3].key[127:64];
        mk1    = tbl[3].key[63:0];
        pt3    = share3(tbl[3].pt);
        start3 = 1'b1;
        dones  = 0;
        for (int i = 0; i < 3; i++) dlist[i] = 0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (done3) begin
                if (dones < 3) dlist[dones] = k;
                dones++;
                check($sformatf("seqC_ct%0d", dones), xor3(ct3), tbl[3].ct);
            end
        end
        start3 = 1'b0;
        check("seqC_done_count", 64'(dones), 64'd3);
        check("seqC_first", 64'(dlist[0]), 64'd48);
        check("seqC_gap1", 64'(dlist[1] - dlist[0]), 64'd49);
        check("seqC_gap2", 64'(dlist[2] - dlist[1]), 64'd49);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
